// File: rtl/dice_throw_receiver_pkg.sv
// Shared types and constants for the dice throw receiver.
// Holds the state encoding, the legal face range and the saturation limits.
package dice_throw_receiver_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StRolling = 2'd1,
        StDone    = 2'd2
    } state_e;

    localparam logic [2:0] THROW_MIN   = 3'd1;
    localparam logic [2:0] THROW_MAX   = 3'd6;
    localparam logic [7:0] TOTAL_SAT   = 8'd255;
    localparam logic [3:0] DOUBLES_SAT = 4'd15;

    function automatic logic throw_legal(input logic [2:0] value);
        return (value >= THROW_MIN) && (value <= THROW_MAX);
    endfunction

endpackage

// File: rtl/dice_throw_receiver_sat_acc.sv
// Saturating adder: acc_i + inc_i, clamped to Max.
// Used for both the running total and the doubles counter.
module sat_acc #(
    parameter int unsigned       Width = 8,
    parameter logic [Width-1:0]  Max   = '1
) (
    input  logic [Width-1:0] acc_i,
    input  logic [Width-1:0] inc_i,
    output logic [Width-1:0] sum_o
);

    logic [Width:0] wide_sum;

    always_comb begin
        wide_sum = {1'b0, acc_i} + {1'b0, inc_i};
        sum_o    = (wide_sum > {1'b0, Max}) ? Max : wide_sum[Width-1:0];
    end

endmodule

// File: rtl/dice_throw_receiver.sv
// Dice throw receiver: captures a face value on the falling edge of button,
// keeps running total, throw count and doubles, and stops once the game ends.
module dice_throw_receiver
    import dice_throw_receiver_pkg::*;
#(
    parameter int unsigned TARGET     = 21,
    parameter int unsigned MAX_THROWS = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       button,
    input  logic       sel,
    input  logic [2:0] throw,
    input  logic       clr,
    output logic [2:0] last_throw,
    output logic       throw_valid,
    output logic [7:0] total,
    output logic [3:0] throw_count,
    output logic [3:0] doubles,
    output logic       err,
    output logic       done
);

    state_e     state_q, state_d;
    logic [2:0] last_q, last_d;
    logic       valid_q, valid_d;
    logic [7:0] total_q, total_d;
    logic [3:0] count_q, count_d;
    logic [3:0] doubles_q, doubles_d;
    logic       err_q, err_d;
    logic       done_q, done_d;

    logic [7:0] total_sum;
    logic [3:0] doubles_sum;
    logic [3:0] count_inc;
    logic       game_over;

    sat_acc #(
        .Width (8),
        .Max   (TOTAL_SAT)
    ) u_total_acc (
        .acc_i (total_q),
        .inc_i ({5'd0, throw}),
        .sum_o (total_sum)
    );

    sat_acc #(
        .Width (4),
        .Max   (DOUBLES_SAT)
    ) u_doubles_acc (
        .acc_i (doubles_q),
        .inc_i (4'd1),
        .sum_o (doubles_sum)
    );

    assign count_inc = count_q + 4'd1;
    assign game_over = ({24'd0, total_sum} >= TARGET) || ({28'd0, count_inc} == MAX_THROWS);

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        valid_d   = 1'b0;
        total_d   = total_q;
        count_d   = count_q;
        doubles_d = doubles_q;
        err_d     = err_q;

        if (clr) begin
            state_d   = StIdle;
            last_d    = '0;
            total_d   = '0;
            count_d   = '0;
            doubles_d = '0;
            err_d     = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (button && !sel) state_d = StRolling;
                end
                StRolling: begin
                    if (sel) begin
                        state_d = StIdle;
                    end else if (!button) begin
                        // Capture edge: the die has stopped.
                        if (throw_legal(throw)) begin
                            last_d  = throw;
                            total_d = total_sum;
                            count_d = count_inc;
                            valid_d = 1'b1;
                            if ((count_q != 4'd0) && (throw == last_q)) doubles_d = doubles_sum;
                            state_d = game_over ? StDone : StIdle;
                        end else begin
                            err_d   = 1'b1;
                            state_d = StIdle;
                        end
                    end
                end
                StDone: state_d = StDone;
                default: state_d = StIdle;
            endcase
        end

        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            last_q    <= '0;
            valid_q   <= 1'b0;
            total_q   <= '0;
            count_q   <= '0;
            doubles_q <= '0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            valid_q   <= valid_d;
            total_q   <= total_d;
            count_q   <= count_d;
            doubles_q <= doubles_d;
            err_q     <= err_d;
            done_q    <= done_d;
        end
    end

    assign last_throw  = last_q;
    assign throw_valid = valid_q;
    assign total       = total_q;
    assign throw_count = count_q;
    assign doubles     = doubles_q;
    assign err         = err_q;
    assign done        = done_q;

endmodule

// File: tb/tb_dice_throw_receiver.sv
// Directed self-checking bench for dice_throw_receiver with default parameters.
module tb_dice_throw_receiver;

    logic       clk = 1'b0;
    logic       rst;
    logic       button;
    logic       sel;
    logic [2:0] throw;
    logic       clr;
    logic [2:0] last_throw;
    logic       throw_valid;
    logic [7:0] total;
    logic [3:0] throw_count;
    logic [3:0] doubles;
    logic       err;
    logic       done;

    int checks    = 0;
    int failures  = 0;
    int pulse_cnt = 0;

    logic [21:0] obs;
    assign obs = {last_throw, throw_valid, total, throw_count, doubles, err, done};

    dice_throw_receiver #(
        .TARGET     (21),
        .MAX_THROWS (15)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .button      (button),
        .sel         (sel),
        .throw       (throw),
        .clr         (clr),
        .last_throw  (last_throw),
        .throw_valid (throw_valid),
        .total       (total),
        .throw_count (throw_count),
        .doubles     (doubles),
        .err         (err),
        .done        (done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (throw_valid === 1'b1) pulse_cnt <= pulse_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
    endtask

    // Button high for three edges, then released; v1/v2 sampled after the
    // capture edge and one edge later.
    task automatic do_throw(input logic [2:0] v, output logic v1, output logic v2);
        throw  = v;
        button = 1'b1;
        tick(3);
        button = 1'b0;
        tick(1);
        v1 = throw_valid;
        tick(1);
        v2 = throw_valid;
    endtask

    task automatic test_reset();
        rst = 1'b0; button = 1'b0; sel = 1'b0; throw = 3'd0; clr = 1'b0;
        #3;
        checks++;
        if (obs !== 22'd0) begin
            failures++;
            $display("FAIL reset_state got=%h want=%h", obs, 22'd0);
        end
        tick(2);
        rst = 1'b1;
        tick(2);
        checks++;
        if (obs !== 22'd0) begin
            failures++;
            $display("FAIL reset_release got=%h want=%h", obs, 22'd0);
        end
    endtask

    task automatic test_basic();
        logic v1, v2;
        int   base;
        do_clr();
        base = pulse_cnt;
        do_throw(3'd3, v1, v2);
        checks++;
        if ({v1, v2} !== 2'b10) begin
            failures++;
            $display("FAIL valid_pulse got=%b want=%b", {v1, v2}, 2'b10);
        end
        checks++;
        if (last_throw !== 3'd3) begin
            failures++;
            $display("FAIL last_throw_first got=%0d want=3", last_throw);
        end
        do_throw(3'd5, v1, v2);
        do_throw(3'd2, v1, v2);
        checks++;
        if (total !== 8'd10 || throw_count !== 4'd3 || doubles !== 4'd0 || err !== 1'b0
            || done !== 1'b0) begin
            failures++;
            $display("FAIL basic_totals got total=%0d count=%0d doubles=%0d err=%b done=%b want 10 3 0 0 0",
                     total, throw_count, doubles, err, done);
        end
        checks++;
        if (pulse_cnt - base != 3) begin
            failures++;
            $display("FAIL basic_pulses got=%0d want=3", pulse_cnt - base);
        end
    endtask

    task automatic test_doubles();
        logic v1, v2;
        do_clr();
        do_throw(3'd4, v1, v2);
        do_throw(3'd4, v1, v2);
        do_throw(3'd4, v1, v2);
        checks++;
        if (doubles !== 4'd2 || total !== 8'd12 || last_throw !== 3'd4 || throw_count !== 4'd3) begin
            failures++;
            $display("FAIL doubles got doubles=%0d total=%0d last=%0d count=%0d want 2 12 4 3",
                     doubles, total, last_throw, throw_count);
        end
    endtask

    task automatic test_illegal();
        logic v1, v2;
        int   base;
        do_clr();
        do_throw(3'd2, v1, v2);
        base = pulse_cnt;
        do_throw(3'd7, v1, v2);
        checks++;
        if (err !== 1'b1 || total !== 8'd2 || throw_count !== 4'd1 || last_throw !== 3'd2) begin
            failures++;
            $display("FAIL illegal_seven got err=%b total=%0d count=%0d last=%0d want 1 2 1 2",
                     err, total, throw_count, last_throw);
        end
        checks++;
        if (pulse_cnt != base) begin
            failures++;
            $display("FAIL illegal_no_pulse got=%0d want=0", pulse_cnt - base);
        end
        do_throw(3'd0, v1, v2);
        checks++;
        if (err !== 1'b1 || throw_count !== 4'd1 || total !== 8'd2) begin
            failures++;
            $display("FAIL illegal_zero got err=%b count=%0d total=%0d want 1 1 2",
                     err, throw_count, total);
        end
        do_clr();
        checks++;
        if (obs !== 22'd0) begin
            failures++;
            $display("FAIL clr_clears_err got=%h want=%h", obs, 22'd0);
        end
    endtask

    task automatic test_target();
        logic v1, v2;
        do_clr();
        do_throw(3'd6, v1, v2);
        do_throw(3'd6, v1, v2);
        do_throw(3'd6, v1, v2);
        checks++;
        if (total !== 8'd18 || done !== 1'b0) begin
            failures++;
            $display("FAIL target_below got total=%0d done=%b want 18 0", total, done);
        end
        do_throw(3'd3, v1, v2);
        checks++;
        if (total !== 8'd21 || done !== 1'b1 || throw_count !== 4'd4 || doubles !== 4'd2) begin
            failures++;
            $display("FAIL target_reached got total=%0d done=%b count=%0d doubles=%0d want 21 1 4 2",
                     total, done, throw_count, doubles);
        end
        do_throw(3'd5, v1, v2);
        checks++;
        if (total !== 8'd21 || throw_count !== 4'd4 || done !== 1'b1 || v1 !== 1'b0) begin
            failures++;
            $display("FAIL done_ignores got total=%0d count=%0d done=%b valid=%b want 21 4 1 0",
                     total, throw_count, done, v1);
        end
        do_clr();
        checks++;
        if (done !== 1'b0 || total !== 8'd0) begin
            failures++;
            $display("FAIL done_clr got done=%b total=%0d want 0 0", done, total);
        end
    endtask

    task automatic test_max_throws();
        logic v1, v2;
        do_clr();
        for (int i = 0; i < 14; i++) do_throw(3'd1, v1, v2);
        checks++;
        if (throw_count !== 4'd14 || done !== 1'b0 || total !== 8'd14 || doubles !== 4'd13) begin
            failures++;
            $display("FAIL max_minus_one got count=%0d done=%b total=%0d doubles=%0d want 14 0 14 13",
                     throw_count, done, total, doubles);
        end
        do_throw(3'd1, v1, v2);
        checks++;
        if (throw_count !== 4'd15 || done !== 1'b1 || total !== 8'd15 || doubles !== 4'd14) begin
            failures++;
            $display("FAIL max_throws got count=%0d done=%b total=%0d doubles=%0d want 15 1 15 14",
                     throw_count, done, total, doubles);
        end
    endtask

    task automatic test_sel_abort();
        logic v1, v2;
        int   base;
        do_clr();
        base   = pulse_cnt;
        throw  = 3'd4;
        button = 1'b1;
        tick(2);
        sel = 1'b1;
        tick(1);
        button = 1'b0;
        tick(2);
        sel = 1'b0;
        tick(2);
        checks++;
        if (obs !== 22'd0 || pulse_cnt != base) begin
            failures++;
            $display("FAIL sel_abort got=%h pulses=%0d want=%h 0", obs, pulse_cnt - base, 22'd0);
        end
        sel = 1'b1;
        do_throw(3'd5, v1, v2);
        sel = 1'b0;
        tick(1);
        checks++;
        if (obs !== 22'd0 || pulse_cnt != base) begin
            failures++;
            $display("FAIL sel_traffic got=%h pulses=%0d want=%h 0", obs, pulse_cnt - base, 22'd0);
        end
    endtask

    task automatic test_clr_capture();
        do_clr();
        throw  = 3'd5;
        button = 1'b1;
        tick(3);
        button = 1'b0;
        clr    = 1'b1;
        tick(1);
        clr = 1'b0;
        checks++;
        if (obs !== 22'd0) begin
            failures++;
            $display("FAIL clr_vs_capture got=%h want=%h", obs, 22'd0);
        end
        tick(2);
        checks++;
        if (obs !== 22'd0) begin
            failures++;
            $display("FAIL clr_discard_later got=%h want=%h", obs, 22'd0);
        end
    endtask

    task automatic test_rst_mid();
        logic v1, v2;
        do_clr();
        do_throw(3'd3, v1, v2);
        throw  = 3'd6;
        button = 1'b1;
        tick(2);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (obs !== 22'd0) begin
            failures++;
            $display("FAIL rst_async got=%h want=%h", obs, 22'd0);
        end
        rst    = 1'b1;
        button = 1'b0;
        tick(3);
        checks++;
        if (obs !== 22'd0) begin
            failures++;
            $display("FAIL rst_abort_throw got=%h want=%h", obs, 22'd0);
        end
    endtask

    task automatic test_short_pulse();
        do_clr();
        #2;
        throw  = 3'd4;
        button = 1'b1;
        #2;
        button = 1'b0;
        tick(3);
        checks++;
        if (obs !== 22'd0) begin
            failures++;
            $display("FAIL short_pulse got=%h want=%h", obs, 22'd0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_doubles();
        test_illegal();
        test_target();
        test_max_throws();
        test_sel_abort();
        test_clr_capture();
        test_rst_mid();
        test_short_pulse();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dice_throw_receiver.md
DICE_THROW_RECEIVER -- requirements
Module: dice_throw_receiver

Interface
REQ-001 Parameter TARGET, default 21: total at or above which the game ends.
REQ-002 Parameter MAX_THROWS, default 15: throw count at which the game ends regardless of total.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 button  input  1  high while the die rolls; the high-to-low transition ends a throw.
REQ-006 sel  input  1  0 = dice mode (throws accepted); 1 = traffic mode (throws ignored).
REQ-007 throw  input  3  face value presented by the dice/traffic mux; legal range 1..6.
REQ-008 clr  input  1  synchronous game clear; priority over all other inputs except rst.
REQ-009 last_throw  output  3  most recent legal throw value.
REQ-010 throw_valid  output  1  one-cycle pulse when a legal throw is accepted.
REQ-011 total  output  8  running sum of accepted throws.
REQ-012 throw_count  output  4  number of accepted throws.
REQ-013 doubles  output  4  number of accepted throws equal to the previous accepted throw.
REQ-014 err  output  1  sticky flag: illegal throw value (0 or 7) captured.
REQ-015 done  output  1  high while in state DONE.

Function
REQ-016 States: IDLE, ROLLING, DONE.
REQ-017 IDLE -> ROLLING when button=1 and sel=0.
REQ-018 ROLLING, button=1, sel=0: remain in ROLLING.
REQ-019 ROLLING, sel=1: return to IDLE; nothing captured, no output change.
REQ-020 ROLLING, button=0, sel=0: sample throw on that edge (the capture edge).
REQ-021 Legal capture (1..6) on the capture edge: last_throw<=throw; total<=total+throw, saturating at 255; throw_count<=throw_count+1; throw_valid=1 for exactly the following cycle.
REQ-022 doubles increments on a legal capture only if throw_count>0 and throw equals last_throw before update; it saturates at 15.
REQ-023 Illegal capture (0 or 7): err<=1; last_throw, total, throw_count and doubles unchanged; throw_valid stays 0; next state IDLE.
REQ-024 After a legal capture, next state is DONE if the updated total>=TARGET or the updated throw_count==MAX_THROWS; otherwise IDLE.
REQ-025 Latency: one clock from the button-low capture edge to visible outputs.
REQ-026 DONE: all counters and flags hold; button and sel ignored; done=1.
REQ-027 clr=1 in any state, on the next edge: state IDLE and every output returns to its reset value, including err.
REQ-028 clr and a capture edge coinciding: clr wins; the throw is discarded.
REQ-029 A button pulse shorter than one clock that is never sampled high produces no capture.

Reset
REQ-030 rst=0 asynchronously forces state IDLE, last_throw=0, throw_valid=0, total=0, throw_count=0, doubles=0, err=0, done=0.
REQ-031 Reset asserted mid-throw (ROLLING) aborts the throw; after reset release, capture requires a fresh 0->1->0 button sequence.
REQ-032 All outputs are registered; no combinational path runs from inputs to outputs.

Structure
REQ-033 The shared package holds the state encoding (IDLE=0, ROLLING=1, DONE=2, 2 bits), THROW_MIN=1, THROW_MAX=6, and the saturation limits 255 and 15.
REQ-034 The block has one sub-module, sat_acc: a parameterised-width saturating adder used for total and for doubles.
REQ-035 Target size is 120-400 lines of RTL; no memories and no derived clocks.

Verification
REQ-036 Reset, then throws 3,5,2 (button high 3 cycles each, sel=0): required total=10, throw_count=3, doubles=0, err=0, exactly three throw_valid pulses.
REQ-037 Throws 4,4,4: required doubles=2, total=12, last_throw=4.
REQ-038 Throw value 7, then throw 0: required err=1 (sticky), total and throw_count unchanged; then clr: required err=0.
REQ-039 Throws 6,6,6,3 with TARGET=21: required done=1 after the fourth throw (total=21); a further throw of 5 is ignored and total stays 21.
REQ-040 sel raised to 1 while button is high, button then dropped: required no capture and state IDLE; with sel=1 throughout, no capture at all.
REQ-041 rst pulsed low while in ROLLING, button then dropped without a new rise: required no capture and all outputs at 0.
